mode_select_menu: RTL and testbench
===================================

// Module: mode_select_menu
// PURPOSE
//  Parametrised mode-select screen controller: N_MODES selectable game modes, cursor navigation (UP/DOWN
//  with wrap), confirm (OK), cancel (BACK), press edge detection, optional player-2 input, idle timeout
//  auto-select. Sits between IR decoders and top-level game FSM; active only while select_mode_screen=1.
// PARAMETERS
//  N_MODES        4           number of selectable modes (>=2); mode 0 = learn mode
//  IR_W           16          width of each IR button vector
//  UP_BIT         0           ir bit index for UP
//  DOWN_BIT       1           ir bit index for DOWN
//  OK_BIT         2           ir bit index for OK/confirm
//  BACK_BIT       15          ir bit index for BACK/cancel
//  DEFAULT_MODE   0           cursor value after reset/entry (<N_MODES)
//  TIMEOUT_CYC    50000000    idle cycles in BROWSE before auto-confirm; 0 disables timeout
// PORTS
//  clk                 in   1      system clock, all logic posedge
//  resetn              in   1      asynchronous active-low reset
//  select_mode_screen  in   1      screen enable from game FSM
//  two_player_mode     in   1      1: accept ir_in_p2 as well as ir_in_p1
//  ir_in_p1            in   IR_W   player-1 IR button vector (level, held while key down)
//  ir_in_p2            in   IR_W   player-2 IR button vector
//  cursor              out  CW     highlighted mode, CW = $clog2(N_MODES)
//  mode_index          out  CW     confirmed mode (valid while selected_a_mode=1)
//  selected_a_mode     out  1      1 = a mode is confirmed
//  mode_valid          out  1      1-cycle pulse on the cycle selected_a_mode rises
//  learn               out  1      1 when selected_a_mode=1 and mode_index==0
// BEHAVIOUR
//  Reset (resetn=0, async): state=IDLE, cursor=DEFAULT_MODE, mode_index=0, selected_a_mode=0,
//   mode_valid=0, learn=0, timeout counter=0, press history=0.
//  Press event: src = ir_in_p1, or ir_in_p2 if two_player_mode=1 and ir_in_p1==0 (p1 wins ties).
//   Event fires on the cycle |src goes 0->1 (registered previous |src); held keys give one event;
//   a second key while one is held gives no event. Only bits UP/DOWN/OK/BACK act; priority
//   OK > BACK > UP > DOWN if several of them are set in the event cycle. Other bits: no action.
//  States:
//   IDLE: outputs held at reset values except cursor. select_mode_screen=1 -> BROWSE next cycle,
//    cursor=DEFAULT_MODE, counter cleared. A key already held on entry gives no event.
//   BROWSE: UP -> cursor-1 (0 wraps to N_MODES-1); DOWN -> cursor+1 (N_MODES-1 wraps to 0);
//    BACK -> no effect; OK -> DONE with mode_index=cursor. Each event clears the counter; otherwise
//    it increments; at count==TIMEOUT_CYC-1 -> DONE with mode_index=cursor (same as OK).
//   DONE: selected_a_mode=1, learn=(mode_index==0); mode_valid=1 only on first DONE cycle
//    (registered, 1 cycle after the OK event/timeout cycle). BACK -> BROWSE, selected_a_mode=0,
//    learn=0, cursor kept, counter cleared. UP/DOWN/OK ignored.
//  select_mode_screen=0 in any state -> IDLE next cycle, selected_a_mode=0, learn=0, mode_valid=0;
//   overrides a same-cycle event. resetn low mid-operation -> immediate reset values.
//  Counter width $clog2(TIMEOUT_CYC+1); saturates, never wraps. All outputs registered.
// TESTING
//  1 reset, enable=1, p1 DOWN pulse x3 (N_MODES=4) -> cursor 1,2,3; 4th DOWN -> cursor 0 (wrap).
//  2 from cursor 0, UP -> cursor 3; OK -> next cycle selected_a_mode=1, mode_index=3, mode_valid
//    high exactly 1 cycle, learn=0; OK at cursor 0 -> learn=1.
//  3 DOWN held 20 cycles -> cursor advances by 1 only; p1=UP,p2=DOWN same cycle, 2P=1 -> cursor-1;
//    p2 DOWN with two_player_mode=0 -> no change.
//  4 TIMEOUT_CYC=10, no keys after entry -> DONE after 10 BROWSE cycles, mode_index=DEFAULT_MODE;
//    a key at cycle 9 restarts count.
//  5 in DONE, BACK -> selected_a_mode=0, cursor kept; then OK reconfirms with new mode_valid pulse.
//  6 drop select_mode_screen in DONE -> IDLE, outputs 0; resetn low mid-BROWSE -> cursor=DEFAULT_MODE
//    asynchronously, no mode_valid.

Source files
------------

// File: rtl/mode_select_menu.sv
// Mode-select screen controller: cursor navigation over N_MODES entries, confirm/cancel,
// single-event-per-press edge detection, optional player-2 input and idle auto-confirm.
module mode_select_menu #(
    parameter int N_MODES      = 4,
    parameter int IR_W         = 16,
    parameter int UP_BIT       = 0,
    parameter int DOWN_BIT     = 1,
    parameter int OK_BIT       = 2,
    parameter int BACK_BIT     = 15,
    parameter int DEFAULT_MODE = 0,
    parameter int TIMEOUT_CYC  = 50000000,
    localparam int CW          = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            select_mode_screen,
    input  logic            two_player_mode,
    input  logic [IR_W-1:0] ir_in_p1,
    input  logic [IR_W-1:0] ir_in_p2,
    output logic [CW-1:0]   cursor,
    output logic [CW-1:0]   mode_index,
    output logic            selected_a_mode,
    output logic            mode_valid,
    output logic            learn
);

    localparam int          TW        = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit          TO_EN     = (TIMEOUT_CYC > 0);
    localparam logic [CW-1:0] CUR_DEF  = CW'(DEFAULT_MODE);
    localparam logic [CW-1:0] CUR_LAST = CW'(N_MODES - 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] CNT_MAX  = {TW{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BROWSE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cursor_r, cursor_s;
    logic [CW-1:0]   mode_r, mode_s;
    logic            sel_r, sel_s;
    logic            valid_r, valid_s;
    logic            learn_r, learn_s;
    logic [TW-1:0]   cnt_r, cnt_s;
    logic            prev_any_r;

    logic [IR_W-1:0] src_s;
    logic            any_s;
    logic            ev_s;
    logic            ev_ok_s, ev_back_s, ev_up_s, ev_down_s;

    // Player 1 owns the remote whenever any of its keys is down.
    always_comb begin
        src_s = {IR_W{1'b0}};
        if (ir_in_p1 != {IR_W{1'b0}}) begin
            src_s = ir_in_p1;
        end else if (two_player_mode) begin
            src_s = ir_in_p2;
        end else begin
            src_s = {IR_W{1'b0}};
        end
    end

    assign any_s     = |src_s;
    assign ev_s      = any_s & ~prev_any_r;
    assign ev_ok_s   = ev_s & src_s[OK_BIT];
    assign ev_back_s = ev_s & src_s[BACK_BIT];
    assign ev_up_s   = ev_s & src_s[UP_BIT];
    assign ev_down_s = ev_s & src_s[DOWN_BIT];

    // Next-state and next-output logic; screen disable overrides any same-cycle key event.
    always_comb begin
        state_s  = state_r;
        cursor_s = cursor_r;
        mode_s   = mode_r;
        sel_s    = sel_r;
        valid_s  = 1'b0;
        learn_s  = learn_r;
        cnt_s    = cnt_r;
        if (!select_mode_screen) begin
            state_s = ST_IDLE;
            mode_s  = {CW{1'b0}};
            sel_s   = 1'b0;
            learn_s = 1'b0;
            cnt_s   = {TW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s  = ST_BROWSE;
                    cursor_s = CUR_DEF;
                    cnt_s    = {TW{1'b0}};
                end
                ST_BROWSE: begin
                    if (ev_ok_s || (TO_EN && !ev_back_s && !ev_up_s && !ev_down_s
                                    && cnt_r == CNT_LAST)) begin
                        state_s = ST_DONE;
                        mode_s  = cursor_r;
                        sel_s   = 1'b1;
                        valid_s = 1'b1;
                        learn_s = (cursor_r == {CW{1'b0}});
                        cnt_s   = {TW{1'b0}};
                    end else if (ev_back_s) begin
                        cnt_s = {TW{1'b0}};
                    end else if (ev_up_s) begin
                        cursor_s = (cursor_r == {CW{1'b0}}) ? CUR_LAST : cursor_r - CW'(1);
                        cnt_s    = {TW{1'b0}};
                    end else if (ev_down_s) begin
                        cursor_s = (cursor_r == CUR_LAST) ? {CW{1'b0}} : cursor_r + CW'(1);
                        cnt_s    = {TW{1'b0}};
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_s = cnt_r + TW'(1);
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_DONE: begin
                    if (ev_back_s) begin
                        state_s = ST_BROWSE;
                        sel_s   = 1'b0;
                        learn_s = 1'b0;
                        cnt_s   = {TW{1'b0}};
                    end else begin
                        state_s = ST_DONE;
                    end
                end
                default: begin
                    state_s  = ST_IDLE;
                    cursor_s = CUR_DEF;
                    mode_s   = {CW{1'b0}};
                    sel_s    = 1'b0;
                    learn_s  = 1'b0;
                    cnt_s    = {TW{1'b0}};
                end
            endcase
        end
    end

    // State, output and press-history registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            cursor_r   <= CUR_DEF;
            mode_r     <= {CW{1'b0}};
            sel_r      <= 1'b0;
            valid_r    <= 1'b0;
            learn_r    <= 1'b0;
            cnt_r      <= {TW{1'b0}};
            prev_any_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            cursor_r   <= cursor_s;
            mode_r     <= mode_s;
            sel_r      <= sel_s;
            valid_r    <= valid_s;
            learn_r    <= learn_s;
            cnt_r      <= cnt_s;
            prev_any_r <= any_s;
        end
    end

    assign cursor          = cursor_r;
    assign mode_index      = mode_r;
    assign selected_a_mode = sel_r;
    assign mode_valid      = valid_r;
    assign learn           = learn_r;

endmodule

// File: tb/tb_mode_select_menu.sv
// Directed bench for mode_select_menu (N_MODES=4, TIMEOUT_CYC=10): vector table plus
// hand-written sequences for held keys, idle timeout and asynchronous reset.
module tb_mode_select_menu;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        select_mode_screen = 1'b0;
    logic        two_player_mode = 1'b0;
    logic [15:0] ir_in_p1 = 16'h0000;
    logic [15:0] ir_in_p2 = 16'h0000;
    logic [1:0]  cursor, mode_index;
    logic        selected_a_mode, mode_valid, learn;

    int n_total = 0;
    int n_pass  = 0;

    localparam logic [15:0] K_U  = 16'h0001;
    localparam logic [15:0] K_D  = 16'h0002;
    localparam logic [15:0] K_OK = 16'h0004;
    localparam logic [15:0] K_BK = 16'h8000;
    localparam logic [15:0] K_NO = 16'h0000;

    mode_select_menu #(
        .N_MODES(4), .IR_W(16), .UP_BIT(0), .DOWN_BIT(1), .OK_BIT(2), .BACK_BIT(15),
        .DEFAULT_MODE(0), .TIMEOUT_CYC(10)
    ) dut (
        .clk(clk), .resetn(resetn), .select_mode_screen(select_mode_screen),
        .two_player_mode(two_player_mode), .ir_in_p1(ir_in_p1), .ir_in_p2(ir_in_p2),
        .cursor(cursor), .mode_index(mode_index), .selected_a_mode(selected_a_mode),
        .mode_valid(mode_valid), .learn(learn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        scr;
        logic        tp;
        logic [15:0] p1;
        logic [15:0] p2;
        logic [1:0]  cur;
        logic [1:0]  mi;
        logic        sel;
        logic        val;
        logic        lrn;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic scr, input logic tp, input logic [15:0] p1,
                                input logic [15:0] p2, input logic [1:0] cur, input logic [1:0] mi,
                                input logic sel, input logic val, input logic lrn);
        vec_t v;
        v.scr = scr; v.tp = tp; v.p1 = p1; v.p2 = p2;
        v.cur = cur; v.mi = mi; v.sel = sel; v.val = val; v.lrn = lrn;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic scr, input logic tp, input logic [15:0] p1, input logic [15:0] p2);
        select_mode_screen = scr;
        two_player_mode    = tp;
        ir_in_p1           = p1;
        ir_in_p2           = p2;
    endtask

    initial begin
        // scr tp p1 p2 -> cursor mode_index sel valid learn (after the clock edge)
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd0, 2'd0, 0, 0, 0)); // enter browse
        vt.push_back(mk(1, 0, K_D,  K_NO, 2'd1, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd1, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_D,  K_NO, 2'd2, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd2, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_D,  K_NO, 2'd3, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd3, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_D,  K_NO, 2'd0, 2'd0, 0, 0, 0)); // wrap 3->0
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd0, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_U,  K_NO, 2'd3, 2'd0, 0, 0, 0)); // wrap 0->3
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd3, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_OK, K_NO, 2'd3, 2'd3, 1, 1, 0)); // confirm mode 3
        vt.push_back(mk(1, 0, K_OK, K_NO, 2'd3, 2'd3, 1, 0, 0));
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd3, 2'd3, 1, 0, 0));
        vt.push_back(mk(1, 0, K_BK, K_NO, 2'd3, 2'd3, 0, 0, 0)); // back to browse
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd3, 2'd3, 0, 0, 0));
        vt.push_back(mk(1, 0, K_D,  K_NO, 2'd0, 2'd3, 0, 0, 0));
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd0, 2'd3, 0, 0, 0));
        vt.push_back(mk(1, 0, K_OK, K_NO, 2'd0, 2'd0, 1, 1, 1)); // learn mode
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd0, 2'd0, 1, 0, 1));
        vt.push_back(mk(1, 0, K_BK, K_NO, 2'd0, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd0, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 1, K_U,  K_D,  2'd3, 2'd0, 0, 0, 0)); // p1 wins tie
        vt.push_back(mk(1, 1, K_NO, K_NO, 2'd3, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 0, K_NO, K_D,  2'd3, 2'd0, 0, 0, 0)); // p2 ignored in 1P
        vt.push_back(mk(1, 0, K_NO, K_NO, 2'd3, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 1, K_NO, K_D,  2'd0, 2'd0, 0, 0, 0)); // p2 accepted in 2P
        vt.push_back(mk(1, 1, K_NO, K_NO, 2'd0, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 1, K_D,  K_NO, 2'd1, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 1, K_D | K_U, K_NO, 2'd1, 2'd0, 0, 0, 0)); // second key while held
        vt.push_back(mk(1, 1, K_NO, K_NO, 2'd1, 2'd0, 0, 0, 0));
        vt.push_back(mk(1, 1, K_D | K_OK, K_NO, 2'd1, 2'd1, 1, 1, 0)); // OK beats DOWN
        vt.push_back(mk(1, 1, K_NO, K_NO, 2'd1, 2'd1, 1, 0, 0));
        vt.push_back(mk(1, 1, K_BK | K_D, K_NO, 2'd1, 2'd1, 0, 0, 0)); // BACK beats DOWN
        vt.push_back(mk(1, 1, K_NO, K_NO, 2'd1, 2'd1, 0, 0, 0));
        vt.push_back(mk(1, 1, 16'h0010, K_NO, 2'd1, 2'd1, 0, 0, 0)); // unmapped key
        vt.push_back(mk(1, 1, K_NO, K_NO, 2'd1, 2'd1, 0, 0, 0));
        vt.push_back(mk(1, 1, K_BK, K_NO, 2'd1, 2'd1, 0, 0, 0)); // BACK in browse: no effect
        vt.push_back(mk(1, 1, K_NO, K_NO, 2'd1, 2'd1, 0, 0, 0));
        vt.push_back(mk(0, 0, K_NO, K_NO, 2'd1, 2'd0, 0, 0, 0)); // leave screen

        #1;
        chk("reset cursor", cursor, 0);
        chk("reset mode_index", mode_index, 0);
        chk("reset selected", selected_a_mode, 0);
        chk("reset mode_valid", mode_valid, 0);
        chk("reset learn", learn, 0);
        step();
        step();
        resetn = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].scr, vt[i].tp, vt[i].p1, vt[i].p2);
            step();
            chk($sformatf("v%0d cursor", i), cursor, vt[i].cur);
            chk($sformatf("v%0d selected", i), selected_a_mode, vt[i].sel);
            chk($sformatf("v%0d mode_valid", i), mode_valid, vt[i].val);
            chk($sformatf("v%0d learn", i), learn, vt[i].lrn);
            if (vt[i].sel || !vt[i].scr)
                chk($sformatf("v%0d mode_index", i), mode_index, vt[i].mi);
        end

        // DOWN held 20 cycles: one step only, and the hold does not stop the idle timeout
        drive(1, 0, K_NO, K_NO);
        step();
        chk("hold entry cursor", cursor, 0);
        for (int k = 1; k <= 20; k++) begin
            drive(1, 0, K_D, K_NO);
            step();
            chk($sformatf("hold%0d cursor", k), cursor, 1);
            chk($sformatf("hold%0d selected", k), selected_a_mode, (k >= 11) ? 1 : 0);
            chk($sformatf("hold%0d mode_valid", k), mode_valid, (k == 11) ? 1 : 0);
        end
        chk("hold mode_index", mode_index, 1);
        drive(0, 0, K_NO, K_NO);
        step();
        chk("drop in done selected", selected_a_mode, 0);
        chk("drop in done mode_index", mode_index, 0);
        chk("drop in done learn", learn, 0);
        chk("drop in done mode_valid", mode_valid, 0);

        // Pure timeout: 10 browse cycles then DONE with the default mode
        drive(1, 0, K_NO, K_NO);
        for (int k = 0; k <= 10; k++) begin
            step();
            chk($sformatf("to%0d selected", k), selected_a_mode, (k == 10) ? 1 : 0);
        end
        chk("to mode_valid", mode_valid, 1);
        chk("to mode_index", mode_index, 0);
        chk("to learn", learn, 1);
        drive(0, 0, K_NO, K_NO);
        step();

        // A key late in the idle window restarts the count
        drive(1, 0, K_NO, K_NO);
        for (int k = 0; k <= 19; k++) begin
            drive(1, 0, (k == 9) ? K_D : K_NO, K_NO);
            step();
            chk($sformatf("rs%0d selected", k), selected_a_mode, (k == 19) ? 1 : 0);
        end
        chk("rs mode_index", mode_index, 1);
        chk("rs mode_valid", mode_valid, 1);
        drive(0, 0, K_NO, K_NO);
        step();

        // Asynchronous reset in the middle of browsing
        drive(1, 0, K_NO, K_NO);
        step();
        drive(1, 0, K_D, K_NO);
        step();
        chk("pre-reset cursor", cursor, 1);
        drive(1, 0, K_NO, K_NO);
        step();
        #2;
        resetn = 1'b0;
        #1;
        chk("async reset cursor", cursor, 0);
        chk("async reset selected", selected_a_mode, 0);
        chk("async reset mode_valid", mode_valid, 0);
        step();
        chk("held reset mode_valid", mode_valid, 0);
        chk("held reset cursor", cursor, 0);
        resetn = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
